// File: rtl/rr_mux_arb.sv
// N-channel W-bit selector with a single registered output stage.
// Fixed-select or round-robin grant, valid/ready on inputs and output.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_data  [N*W]       packed channel data, ch i at [i*W +: W]
//   in_valid [N]         per-channel valid
//   in_ready [N]         per-channel grant, onehot0
//   mode                 0 = fixed select, 1 = round-robin
//   sel      [SEL_W]     channel chosen in fixed mode
//   out_data [W]         registered data
//   out_ch   [SEL_W]     source channel of out_data
//   out_valid            output register full
//   out_ready            downstream accepts
module rr_mux_arb #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic             r_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_load_en;
  logic             w_fix_vld;
  logic [SEL_W-1:0] w_fix_idx;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;
  logic [SEL_W-1:0] w_ptr_nxt;

  assign w_load_en = !r_valid | out_ready;

  // Only an in-range sel can match a loop index,
  // so sel >= NUM_CH grants nothing.
  always_comb begin
    w_fix_vld = 1'b0;
    w_fix_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        w_fix_vld = 1'b1;
        w_fix_idx = SEL_W'(i);
      end
    end
  end

  // Scan from the farthest offset down so the
  // nearest valid channel after rr_ptr wins.
  always_comb begin
    logic [SEL_W:0] w_sum;
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    w_sum    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
      if (w_sum >= (SEL_W+1)'(NUM_CH))
        w_sum = w_sum - (SEL_W+1)'(NUM_CH);
      if (in_valid[w_sum[SEL_W-1:0]]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = w_sum[SEL_W-1:0];
      end
    end
  end

  assign w_gnt_vld = mode ? w_rr_vld : w_fix_vld;
  assign w_gnt_idx = mode ? w_rr_idx : w_fix_idx;
  assign w_xfer    = w_gnt_vld & w_load_en & rst_n;

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt_idx == SEL_W'(i))
        w_gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_xfer && w_gnt_idx == SEL_W'(i))
        in_ready[i] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(NUM_CH - 1))
                   ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_ch     <= '0;
      r_valid  <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      if (w_xfer) begin
        r_data  <= w_gnt_data;
        r_ch    <= w_gnt_idx;
        r_valid <= 1'b1;
        if (mode)
          r_rr_ptr <= w_ptr_nxt;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Testbench for rr_mux_arb: directed scenarios plus randomized
// traffic checked against a per-cycle behavioural model.
module tb_rr_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [47:0] d3_data;
  logic [2:0]  d3_valid;
  logic [2:0]  d3_ready;
  logic        d3_mode;
  logic [1:0]  d3_sel;
  logic [15:0] d3_out_data;
  logic [1:0]  d3_out_ch;
  logic        d3_out_valid;
  logic        d3_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int       m_ptr;
  bit       m_vld;
  bit [15:0] m_data;
  int       m_ch;

  always #5 clk = ~clk;

  rr_mux_arb dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel),
    .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_mux_arb #(.WIDTH(16), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d3_data), .in_valid(d3_valid),
    .in_ready(d3_ready), .mode(d3_mode), .sel(d3_sel),
    .out_data(d3_out_data), .out_ch(d3_out_ch),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready)
  );

  function automatic int model_grant();
    int s;
    s = int'(sel);
    if (!mode) return (s < 4 && in_valid[s]) ? s : -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant();
    if (!rst_n || g < 0 || !(!m_vld || out_ready)) return 4'b0;
    return 4'b0001 << g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_vld = 0; m_data = 0; m_ch = 0;
  endtask

  task automatic model_update();
    int g;
    g = model_grant();
    if (rst_n && g >= 0 && (!m_vld || out_ready)) begin
      m_vld  = 1;
      m_data = in_data[g*16 +: 16];
      m_ch   = g;
      if (mode) m_ptr = (g + 1) % 4;
    end else if (m_vld && out_ready) begin
      m_vld = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 4'b1111; in_data = '1;
    mode = 0; sel = 2; out_ready = 1;
    d3_data = '0; d3_valid = '0; d3_mode = 0;
    d3_sel = 0; d3_out_ready = 1;
    model_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 ||
        out_ch !== 2'd0 || in_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL reset: v=%b d=%h ch=%0d rdy=%b want 0/0/0/0",
               out_valid, out_data, out_ch, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fixed();
    in_valid = 4'b0100;
    in_data  = '0;
    in_data[2*16 +: 16] = 16'hBEEF;
    mode = 0; sel = 2; out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL fixed_ready: got %b want 0100", in_ready);
    end
    tick();
    n_checks++;
    if (out_data !== 16'hBEEF || out_ch !== 2'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_out: d=%h ch=%0d v=%b want beef/2/1",
               out_data, out_ch, out_valid);
    end
  endtask

  task automatic test_rr_fairness();
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      in_data[(i%4)*16 +: 16] = d;
      #1;
      n_checks++;
      if (in_ready !== (4'b0001 << (i % 4))) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b want ch %0d", i, in_ready, i % 4);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== d) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: v=%b ch=%0d d=%h want 1/%0d/%h",
                 i, out_valid, out_ch, out_data, i % 4, d);
      end
    end
  endtask

  task automatic test_skip_idle();
    in_valid = 4'b1001; mode = 1; out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL skip_first: got %b want 1000", in_ready);
    end
    tick();
    n_checks++;
    if (in_ready !== 4'b0001 || out_ch !== 2'd3) begin
      n_fail++;
      $display("FAIL skip_wrap: rdy=%b ch=%0d want 0001/3", in_ready, out_ch);
    end
    tick();
    in_valid = 4'b1111;
    #1;
    n_checks++;
    if (in_ready !== 4'b0010 || out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL skip_ptr: rdy=%b ch=%0d want 0010/0", in_ready, out_ch);
    end
  endtask

  task automatic test_backpressure();
    mode = 0; sel = 1; in_valid = 4'b0010; out_ready = 1;
    in_data[1*16 +: 16] = 16'hAAAA;
    tick();
    out_ready = 0; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 16'hAAAA) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b ch=%0d d=%h want 1/1/aaaa",
                 i, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1; sel = 2; in_valid = 4'b0100;
    in_data[2*16 +: 16] = 16'hC0DE;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release: got %b want 0100", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 16'hC0DE) begin
      n_fail++;
      $display("FAIL bp_reload: v=%b ch=%0d d=%h want 1/2/c0de",
               out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] er;
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      #1;
      er = model_ready();
      n_checks++;
      if (in_ready !== er || !$onehot0(in_ready)) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, er);
      end
      tick();
      n_checks++;
      if (out_valid !== m_vld || out_data !== m_data ||
          out_ch !== 2'(m_ch)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: v=%b d=%h ch=%0d want %b/%h/%0d",
                 i, out_valid, out_data, out_ch, m_vld, m_data, m_ch);
      end
    end
  endtask

  task automatic test_mid_reset();
    mode = 1; in_valid = 4'b0100; out_ready = 1;
    in_data[2*16 +: 16] = 16'h1234;
    tick();
    out_ready = 0; in_valid = 4'b0;
    #3;
    rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst: v=%b rdy=%b want 0/0000", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    in_valid = 4'b1111; out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_first: got %b want 0001", in_ready);
    end
    tick();
    in_valid = 4'b0;
  endtask

  task automatic test_range3();
    d3_mode = 0; d3_sel = 2'd3; d3_valid = 3'b111;
    d3_out_ready = 1;
    d3_data = {16'h2222, 16'h1111, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (d3_ready !== 3'b0) begin
        n_fail++;
        $display("FAIL oor_ready[%0d]: got %b want 000", i, d3_ready);
      end
      tick();
      n_checks++;
      if (d3_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL oor_valid[%0d]: got %b want 0", i, d3_out_valid);
      end
    end
    d3_mode = 1; d3_valid = 3'b010;
    #1;
    n_checks++;
    if (d3_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL n3_g1: got %b want 010", d3_ready);
    end
    tick();
    d3_valid = 3'b111;
    #1;
    n_checks++;
    if (d3_ready !== 3'b100 || d3_out_ch !== 2'd1) begin
      n_fail++;
      $display("FAIL n3_g2: rdy=%b ch=%0d want 100/1", d3_ready, d3_out_ch);
    end
    tick();
    #1;
    n_checks++;
    if (d3_ready !== 3'b001 || d3_out_ch !== 2'd2 ||
        d3_out_data !== 16'h2222) begin
      n_fail++;
      $display("FAIL n3_wrap: rdy=%b ch=%0d d=%h want 001/2/2222",
               d3_ready, d3_out_ch, d3_out_data);
    end
    tick();
    n_checks++;
    if (d3_out_ch !== 2'd0 || d3_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL n3_ch0: ch=%0d v=%b want 0/1", d3_out_ch, d3_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_skip_idle();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_range3();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-channel, W-bit selector with one registered output stage and valid/ready handshakes on every input and on the output.
- Supersedes the fixed 16-bit 4:1 combinational selector wherever a shared datapath resource is time-multiplexed between producers. Examples are register-file write-back sources and memory-port requesters.
- Two modes: fixed (external select, as before) and round-robin arbitration.

Parameters:
- WIDTH, 16, data width of every channel and of the output.
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_CH), width of the select/channel-id fields.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (grant); at most one bit high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel selected in fixed mode.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  id of the channel that produced out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_ch=0.
  - round-robin pointer rr_ptr=0.
  - in_ready forced to 0 while rst_n is low.
- Output register state:
  - EMPTY (out_valid=0) or FULL (out_valid=1); this is the only storage.
- load_en = !out_valid | out_ready.
  - A new beat may load in the same cycle the held beat drains, giving full throughput of 1 beat/cycle.
- Grant, combinational from the current inputs and rr_ptr, gated by load_en:
  - Fixed mode: candidate = sel. Grant only if sel < NUM_CH and in_valid[sel]=1. If sel >= NUM_CH, nothing is granted.
  - Round-robin mode: candidate = the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_CH (wrap from NUM_CH-1 to 0).
  - in_ready[g]=1 only for the granted channel g, and only when load_en=1. All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid. in_valid must not depend on in_ready (no loop).
- Transfer on an input channel = in_valid[g] & in_ready[g] at the rising edge. On transfer:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - Round-robin mode only: rr_ptr <= (g+1) mod NUM_CH.
- Output drain = out_valid & out_ready at the edge, with no input transfer in that cycle: out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and transfer in one cycle: the register reloads with the new beat and out_valid stays 1.
- Output hold: while out_valid=1 & out_ready=0, out_data and out_ch are stable and all in_ready are 0.
- Latency: 1 cycle from an input transfer to the beat appearing with out_valid=1.
- rr_ptr:
  - Unchanged in fixed mode.
  - Unchanged in round-robin mode when nothing transfers.
  - Non-power-of-two NUM_CH wraps correctly (e.g. NUM_CH=3: 2 -> 0).
- mode/sel changes:
  - Sampled every cycle; they take effect on the next grant.
  - A beat already held in the output register is never discarded or altered.
- Reset mid-operation: a held beat is dropped (out_valid=0 immediately). In-flight handshakes are aborted with no transfer.
- No input combination produces X on any output. Only one bit of in_ready is ever high (onehot0).

Test Plan:
- Reset, fixed mode: rst_n low with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0.
  - Release reset, mode=0, sel=2, ch2=16'hBEEF -> in_ready=4'b0100.
  - Next cycle: out_data=16'hBEEF, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1… with one beat per cycle and no gaps.
- Skip idle channels: mode=1, rr_ptr=1, in_valid=4'b1001 -> grant 3 then 0 (wrap), rr_ptr=1 afterwards.
- Backpressure:
  - Output FULL with out_ch=1 and out_ready=0 for 5 cycles -> in_ready=0 throughout; out_data and out_ch are stable.
  - Then out_ready=1 with ch2 valid -> same-cycle drain+load, out_valid stays 1, out_ch=2.
- Out-of-range select: NUM_CH=3 build, mode=0, sel=3, all valid -> in_ready=0 and out_valid stays 0.
  - Round-robin mode with rr_ptr=2 and ch2 granted -> rr_ptr wraps to 0.
- Reset mid-operation: out_valid=1 holding 16'h1234, rst_n asserted asynchronously mid-cycle -> out_valid=0 before the next clock edge.
  - After release, the first grant is channel 0 in round-robin mode.
